// File: rtl/core_mem_responder.sv
// Memory responder for the core req/gnt interface: word-addressed backing store,
// configurable wait states before each grant, error responses and protocol monitoring.
module core_mem_responder #(
  parameter logic [63:0] MEM_BASE   = 64'h0000_0000_8000_0000,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned MAX_STALL  = 3,
  parameter bit          RAND_STALL = 1'b1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic        mem_rtype,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  input  logic [1:0]  mem_prv,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata,
  input  logic [3:0]  cfg_stall,
  output logic        prot_viol
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;
  localparam logic [3:0]  MAX_S     = 4'(MAX_STALL);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t state, state_nxt;

  logic [63:0] mem [MEM_WORDS];

  logic [63:0] lat_addr;
  logic        lat_wen;
  logic [7:0]  lat_strb;
  logic [63:0] lat_wdata;
  logic [1:0]  lat_prv;
  logic [3:0]  cnt;
  logic [7:0]  lfsr;

  logic          unused_rtype;
  assign unused_rtype = mem_rtype;

  // In IDLE the decision is made on the live inputs; afterwards on the latched copy.
  logic [63:0]   cur_addr;
  logic          cur_wen;
  logic [7:0]    cur_strb;
  logic [63:0]   cur_off;
  logic          cur_in_range;
  logic          cur_err;
  logic [AW-1:0] cur_idx;

  assign cur_addr     = (state == IDLE) ? mem_addr : lat_addr;
  assign cur_wen      = (state == IDLE) ? mem_wen  : lat_wen;
  assign cur_strb     = (state == IDLE) ? mem_strb : lat_strb;
  assign cur_off      = cur_addr - MEM_BASE;
  assign cur_in_range = (cur_addr >= MEM_BASE) && (cur_off < MEM_BYTES);
  assign cur_idx      = cur_off[AW+2:3];
  assign cur_err      = !cur_in_range || (cur_wen && (cur_strb == '0));

  logic [3:0] lfsr_mod;
  logic [3:0] cfg_clamp;
  logic [3:0] stall;
  logic [7:0] lfsr_nxt;

  assign lfsr_mod  = 4'(32'(lfsr[3:0]) % (MAX_STALL + 1));
  assign cfg_clamp = (cfg_stall > MAX_S) ? MAX_S : cfg_stall;
  assign stall     = RAND_STALL ? lfsr_mod : cfg_clamp;
  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  logic accept;
  logic go_grant;
  logic viol_now;

  assign accept   = (state == IDLE) && mem_req;
  assign go_grant = (state_nxt == GRANT);
  assign viol_now = ((state == WAIT) || (state == GRANT)) &&
                    (!mem_req || (mem_addr != lat_addr) || (mem_wen != lat_wen) ||
                     (mem_strb != lat_strb) || (mem_wdata != lat_wdata) ||
                     (mem_prv != lat_prv));

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req) state_nxt = (stall == '0) ? GRANT : WAIT;
      WAIT:    if (cnt <= 4'd1) state_nxt = GRANT;
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      mem_gnt   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      prot_viol <= 1'b0;
      lfsr      <= LFSR_SEED;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_strb  <= '0;
      lat_wdata <= '0;
      lat_prv   <= '0;
    end else begin
      mem_gnt   <= go_grant;
      mem_err   <= go_grant && cur_err;
      mem_rdata <= (go_grant && !cur_err) ? mem[cur_idx] : '0;
      if (accept) begin
        lat_addr  <= mem_addr;
        lat_wen   <= mem_wen;
        lat_strb  <= mem_strb;
        lat_wdata <= mem_wdata;
        lat_prv   <= mem_prv;
        cnt       <= stall;
        lfsr      <= lfsr_nxt;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (viol_now) prot_viol <= 1'b1;
    end
  end

  // Write commits at the end of the grant cycle, so the grant's rdata is the pre-write word.
  always_ff @(posedge g_clk) begin
    if (!g_reset && (state == GRANT) && lat_wen && !cur_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (lat_strb[i]) mem[cur_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: data path, stalls, errors, protocol flag, reset abort, LFSR stalls.
module tb_core_mem_responder;

  logic        g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        g_reset, mem_req, mem_rtype, mem_wen, mem_gnt, mem_err, prot_viol;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
  logic [1:0]  mem_prv;
  logic [3:0]  cfg_stall;

  logic        r_reset, r_req, r_gnt, r_err, r_viol;
  logic [63:0] r_rdata;

  core_mem_responder #(.RAND_STALL(1'b0), .MAX_STALL(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(mem_req), .mem_rtype(mem_rtype),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_prv(mem_prv), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .cfg_stall(cfg_stall), .prot_viol(prot_viol)
  );

  core_mem_responder #(.RAND_STALL(1'b1), .MAX_STALL(3), .LFSR_SEED(8'hA5)) dut_r (
    .g_clk(g_clk), .g_reset(r_reset), .mem_req(r_req), .mem_rtype(1'b0),
    .mem_addr(64'h8000_0000), .mem_wen(1'b0), .mem_strb(8'h00), .mem_wdata(64'h0),
    .mem_prv(2'b11), .mem_gnt(r_gnt), .mem_err(r_err), .mem_rdata(r_rdata),
    .cfg_stall(4'h0), .prot_viol(r_viol)
  );

  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic        e;
  logic [63:0] r;
  logic        gnt_seen;
  int          run1[4];
  int          run2[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [63:0] a, input logic w, input logic [7:0] s,
                     input logic [63:0] d, output int l, output logic er, output logic [63:0] rd);
    mem_req = 1'b1; mem_addr = a; mem_wen = w; mem_strb = s; mem_wdata = d;
    mem_prv = 2'b11; mem_rtype = w;
    l = 0; er = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge g_clk); #1;
      if (mem_gnt) begin
        l = i; er = mem_err; rd = mem_rdata;
        break;
      end
    end
    @(posedge g_clk); #1;
    mem_req = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic rtxn(output int l);
    r_req = 1'b1;
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge g_clk); #1;
      if (r_gnt) begin
        l = i;
        break;
      end
    end
    @(posedge g_clk); #1;
    r_req = 1'b0;
  endtask

  initial begin
    g_reset = 1'b1; r_reset = 1'b1; r_req = 1'b0;
    mem_req = 1'b0; mem_rtype = 1'b0; mem_addr = '0; mem_wen = 1'b0;
    mem_strb = '0; mem_wdata = '0; mem_prv = '0; cfg_stall = '0;
    dut.mem[0]    <= 64'h0123_4567_89AB_CDEF;
    dut.mem[1]    <= 64'h1111_2222_3333_4444;
    dut.mem[1023] <= 64'hCAFE_F00D_0BAD_BEEF;
    repeat (3) @(posedge g_clk);
    #1;
    g_reset = 1'b0; r_reset = 1'b0;

    chk("rst_gnt",  64'(mem_gnt), 64'd0);
    chk("rst_err",  64'(mem_err), 64'd0);
    chk("rst_rdata", mem_rdata,   64'd0);
    chk("rst_viol", 64'(prot_viol), 64'd0);

    txn(64'h8000_0000, 1'b0, 8'h00, 64'h0, lat, e, r);
    chk("rd0_lat",   64'(lat), 64'd1);
    chk("rd0_err",   64'(e),   64'd0);
    chk("rd0_rdata", r,        64'h0123_4567_89AB_CDEF);

    txn(64'h8000_0000, 1'b1, 8'h0F, 64'hFFFF_FFFF_1122_3344, lat, e, r);
    chk("wr0_lat",   64'(lat), 64'd1);
    chk("wr0_err",   64'(e),   64'd0);
    chk("wr0_old",   r,        64'h0123_4567_89AB_CDEF);
    chk("wr0_store", dut.mem[0], 64'h0123_4567_1122_3344);

    txn(64'h8000_0000, 1'b0, 8'h00, 64'h0, lat, e, r);
    chk("rb0_rdata", r, 64'h0123_4567_1122_3344);

    cfg_stall = 4'd9;
    txn(64'h8000_0008, 1'b0, 8'h00, 64'h0, lat, e, r);
    chk("clamp_lat",   64'(lat), 64'd4);
    chk("rd1_rdata",   r,        64'h1111_2222_3333_4444);

    cfg_stall = 4'd2;
    txn(64'h8000_1FFB, 1'b0, 8'h00, 64'h0, lat, e, r);
    chk("stall2_lat",  64'(lat), 64'd3);
    chk("last_rdata",  r,        64'hCAFE_F00D_0BAD_BEEF);

    cfg_stall = 4'd0;
    txn(64'h8000_2000, 1'b1, 8'hFF, 64'h0, lat, e, r);
    chk("oor_err",    64'(e), 64'd1);
    chk("oor_rdata",  r,      64'd0);
    chk("oor_mem0",   dut.mem[0],    64'h0123_4567_1122_3344);
    chk("oor_mem_hi", dut.mem[1023], 64'hCAFE_F00D_0BAD_BEEF);

    txn(64'h7FFF_FFF8, 1'b0, 8'h00, 64'h0, lat, e, r);
    chk("below_err",   64'(e), 64'd1);
    chk("below_rdata", r,      64'd0);

    txn(64'h8000_0008, 1'b1, 8'h00, 64'h0, lat, e, r);
    chk("nostrb_err",  64'(e), 64'd1);
    chk("nostrb_mem1", dut.mem[1], 64'h1111_2222_3333_4444);
    chk("clean_viol",  64'(prot_viol), 64'd0);

    // Address changes in the cycle after acceptance.
    cfg_stall = 4'd2;
    mem_req = 1'b1; mem_addr = 64'h8000_0008; mem_wen = 1'b0; mem_strb = '0;
    mem_wdata = '0; mem_prv = 2'b11;
    @(posedge g_clk); #1;
    mem_addr = 64'h8000_0010;
    @(posedge g_clk); #1;
    chk("viol_addr", 64'(prot_viol), 64'd1);
    mem_addr = 64'h8000_0008;
    repeat (3) @(posedge g_clk);
    #1;
    mem_req = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    chk("viol_sticky", 64'(prot_viol), 64'd1);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    chk("viol_cleared", 64'(prot_viol), 64'd0);

    // Request dropped mid-wait.
    mem_req = 1'b1; mem_addr = 64'h8000_0008;
    @(posedge g_clk); #1;
    mem_req = 1'b0;
    @(posedge g_clk); #1;
    chk("viol_drop", 64'(prot_viol), 64'd1);
    repeat (4) @(posedge g_clk);
    #1;
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;

    // Reset during WAIT of a write aborts it.
    cfg_stall = 4'd3;
    gnt_seen = 1'b0;
    mem_req = 1'b1; mem_addr = 64'h8000_0008; mem_wen = 1'b1; mem_strb = 8'hFF;
    mem_wdata = 64'h0;
    @(posedge g_clk); #1;
    gnt_seen = gnt_seen | mem_gnt;
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0; mem_req = 1'b0; mem_wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gnt_seen = gnt_seen | mem_gnt;
      @(posedge g_clk); #1;
    end
    chk("abort_nognt", 64'(gnt_seen), 64'd0);
    chk("abort_mem1",  dut.mem[1], 64'h1111_2222_3333_4444);

    // LFSR stalls from seed A5 are 1,2,1,2 and must repeat after reset.
    for (int i = 0; i < 4; i++) rtxn(run1[i]);
    r_reset = 1'b1;
    @(posedge g_clk); #1;
    r_reset = 1'b0;
    for (int i = 0; i < 4; i++) rtxn(run2[i]);
    chk("lfsr_lat0", 64'(run1[0]), 64'd2);
    chk("lfsr_lat1", 64'(run1[1]), 64'd3);
    chk("lfsr_lat2", 64'(run1[2]), 64'd2);
    chk("lfsr_lat3", 64'(run1[3]), 64'd3);
    for (int i = 0; i < 4; i++) chk("lfsr_repeat", 64'(run2[i]), 64'(run1[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Memory responder for the core's `req`/`gnt` memory interface. One instance serves either the instruction port or the data port in simulation and formal benches. It holds a word-addressed backing store and inserts configurable wait states before each grant. It returns read data or an error on the grant cycle, and it flags any initiator protocol violation it sees.

## Interface
Parameters:
- `MEM_BASE`, default 64'h0000_0000_8000_0000: byte address of word 0 of the backing store.
- `MEM_WORDS`, default 1024: backing store depth in 64-bit words; must be a power of two, at least 2.
- `MAX_STALL`, default 3: maximum wait states inserted before `mem_gnt`; range 0..15.
- `RAND_STALL`, default 1: 1 means the stall count comes from an LFSR; 0 means it comes from `cfg_stall`.
- `LFSR_SEED`, default 8'hA5: reset value of the 8-bit LFSR; must be nonzero.

Ports:
- `g_clk`, input, 1: global clock; all logic is on the rising edge.
- `g_reset`, input, 1: synchronous, active-high reset.
- `mem_req`, input, 1: request valid; held until granted.
- `mem_rtype`, input, 1: request type, I or D; informational only.
- `mem_addr`, input, 64: byte address of the request.
- `mem_wen`, input, 1: write enable.
- `mem_strb`, input, 8: byte write strobes.
- `mem_wdata`, input, 64: write data.
- `mem_prv`, input, 2: privilege level of the request.
- `mem_gnt`, output, 1: request complete; one-cycle pulse.
- `mem_err`, output, 1: error response; valid only when `mem_gnt`=1.
- `mem_rdata`, output, 64: read data; valid only when `mem_gnt`=1 and `mem_err`=0.
- `cfg_stall`, input, 4: fixed stall count used when `RAND_STALL`=0; values are clamped to `MAX_STALL`.
- `prot_viol`, output, 1: sticky flag set by any initiator protocol violation.

## Operation
- The state machine has three states: IDLE, WAIT and GRANT.
- In IDLE with `mem_req`=1:
  - Latch addr, wen, strb, wdata and prv.
  - Load the stall counter with s, where s is `lfsr[3:0] % (MAX_STALL+1)` or `min(cfg_stall, MAX_STALL)`.
  - Advance the LFSR (taps 8,6,5,4).
  - Go to GRANT if s=0, otherwise go to WAIT.
- In WAIT, decrement the counter and go to GRANT when it reaches 1.
- In GRANT:
  - Drive `mem_gnt`=1 and return to IDLE.
  - A new request may be accepted in the next cycle.
- The address is in range when `MEM_BASE <= addr < MEM_BASE + 8*MEM_WORDS`. Word index = `(addr - MEM_BASE) >> 3`, truncated to `log2(MEM_WORDS)` bits. Address bits [2:0] are ignored.
- `mem_err`=1 at grant when the address is out of range, or when `mem_wen`=1 and `mem_strb`=0.
  - On error, no write occurs and `mem_rdata`=0.
- Write: on the GRANT clock edge, store byte i from `wdata[8i+7:8i]` for each i where `strb[i]`=1. `mem_rdata` on a write grant equals the pre-write word.
- Read: `mem_rdata` is the word at the index. Reads use the stored value, not any in-flight write; only one transaction is ever in flight.
- Protocol checks in WAIT, or in GRANT before the grant: set `prot_viol` if `mem_req` drops, or if addr, wen, strb, wdata or prv differ from the latched values.
  - `prot_viol` is cleared only by `g_reset`.
- `mem_req`=1 in the GRANT cycle is treated as completing the current request, not as a new one. A new request is sampled only in IDLE.
- Backing store contents are not reset. The bench initialises the store hierarchically. Unwritten words read as X in simulation.

## Timing
- Reset values: state=IDLE, `mem_gnt`=0, `mem_err`=0, `mem_rdata`=0, `prot_viol`=0, LFSR=`LFSR_SEED`, counter=0.
- If `g_reset` is asserted mid-transaction, the transaction is dropped: no write is performed and no grant is issued.
- Latency: a request first seen in IDLE at cycle t gets `mem_gnt` at cycle t+1+s, where s is the stall count loaded at t. The minimum latency is 1 cycle.
- `mem_gnt`, `mem_err` and `mem_rdata` are all registered. No output depends combinationally on an input.
- Back-to-back: peak throughput is one grant every 2 cycles (IDLE is visited between requests).
- The LFSR advances only when a request is accepted, so the stall sequence is deterministic per request.

## Test plan
- Setup: `RAND_STALL`=0, `cfg_stall`=0. Read word 0 (initialised to 64'h0123_4567_89AB_CDEF) at addr 64'h8000_0000. Required: `mem_gnt` 1 cycle later, `mem_err`=0, `mem_rdata`=64'h0123_4567_89AB_CDEF.
- Write with `strb`=8'h0F and `wdata`=64'hFFFF_FFFF_1122_3344 to word 0, then read it back. Required: read returns 64'h0123_4567_1122_3344, and the write grant's `mem_rdata` is the old word.
- Set `cfg_stall`=9 with `MAX_STALL`=3. Required: grant exactly 4 cycles after the request is accepted. Then set `cfg_stall`=2; required: grant 3 cycles after acceptance.
- Request addr 64'h8000_2000 (one past the end for 1024 words). Required: `mem_err`=1, `mem_rdata`=0, and no memory word changes.
- With stall 2, change `mem_addr` in the cycle after acceptance. Required: `prot_viol`=1 and it stays 1 until reset. Separately, drop `mem_req` mid-wait; required: `prot_viol`=1.
- Assert `g_reset` during WAIT of a write. Required: `mem_gnt` is never asserted and the word is unchanged. With `RAND_STALL`=1, two runs from reset give identical stall sequences.
